evt_debounce: RTL and testbench
===============================

EVT_DEBOUNCE -- requirements
Module: evt_debounce

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops (legal value 2 or more).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, giving the consecutive stable synchronized samples required to accept a level change (legal value 1 or more).
REQ-003 The block SHALL have input clk_in, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have input rst_in, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have input raw_in, 1 bit: asynchronous, bouncy source such as a button or switch.
REQ-006 The block SHALL have input edge_sel_in, 2 bits: 00 none, 01 rise, 10 fall, 11 both.
REQ-007 The block SHALL have output clean_out, 1 bit: the debounced level.
REQ-008 The block SHALL have output rise_out, 1 bit: a one-cycle pulse on each accepted 0->1 change.
REQ-009 The block SHALL have output fall_out, 1 bit: a one-cycle pulse on each accepted 1->0 change.
REQ-010 The block SHALL have output evt_out, 1 bit: the selected pulse, suitable to drive evt_in of the event counter.

Function
REQ-011 raw_in SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is "sync", and no other logic samples raw_in.
REQ-012 The FSM SHALL have exactly four states: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
REQ-013 In STABLE_LO, sync=1 SHALL move the FSM to PEND_HI with the counter loaded to 1; otherwise the FSM stays in STABLE_LO.
REQ-014 In STABLE_HI, sync=0 SHALL move the FSM to PEND_LO with the counter loaded to 1; otherwise the FSM stays in STABLE_HI.
REQ-015 In PEND_HI, sync=0 SHALL return the FSM to STABLE_LO with the counter cleared and no output change.
REQ-016 In PEND_HI, when sync=1 and counter+1 would reach DEBOUNCE_CYCLES, the FSM SHALL move to STABLE_HI; otherwise, while sync=1, the counter increments.
REQ-017 PEND_LO SHALL behave symmetrically to PEND_HI: sync=1 returns to STABLE_HI; DEBOUNCE_CYCLES stable low samples move to STABLE_LO.
REQ-018 When DEBOUNCE_CYCLES=1, the FSM SHALL pass from a stable state directly to the opposite stable state on the first differing sample, with no pending cycle.
REQ-019 clean_out SHALL be a register that is 1 exactly while the FSM is in STABLE_HI or PEND_LO.
REQ-020 rise_out SHALL be registered and high for exactly the first cycle clean_out is 1; fall_out SHALL be registered and high for exactly the first cycle clean_out is 0 after having been 1.
REQ-021 Latency from the first raw_in edge sampled high, with no bounce, to clean_out=1 SHALL be SYNC_STAGES + DEBOUNCE_CYCLES clock cycles; falling changes SHALL have the same latency.
REQ-022 evt_out SHALL equal (rise_out AND edge_sel_in[0]) OR (fall_out AND edge_sel_in[1]), combinationally from registered pulses.
REQ-023 A change of edge_sel_in SHALL take effect in the same cycle and SHALL NOT alter FSM state.
REQ-024 rise_out and fall_out SHALL never be high in the same cycle, and at most one pulse SHALL occur per accepted change.
REQ-025 The counter width SHALL be $clog2(DEBOUNCE_CYCLES+1), and the counter SHALL never wrap: it saturates by state exit.

Reset
REQ-026 When rst_in=1, the synchronizer flops, counter, clean_out, rise_out and fall_out SHALL all be 0 and the FSM SHALL be in STABLE_LO on the next edge.
REQ-027 Reset SHALL take priority over every transition, including mid-PEND_HI or PEND_LO; a pending change is discarded without any pulse.
REQ-028 If raw_in is high at reset release, the block SHALL debounce it as a normal rise and emit one rise_out after SYNC_STAGES + DEBOUNCE_CYCLES cycles.

Structure
REQ-029 Package evt_pkg SHALL hold the FSM state enum and the edge_sel encodings EDGE_NONE, EDGE_RISE, EDGE_FALL and EDGE_BOTH.
REQ-030 The synchronizer SHALL be one sub-module, sync_chain, with parameter STAGES, ports clk_in, rst_in, d_in and q_out, and reset value 0.
REQ-031 The FSM, counter and pulse logic SHALL reside in evt_debounce itself.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-032 raw_in 0->1 at cycle 10 and held -> clean_out=1 from cycle 16; rise_out high only in cycle 16; fall_out stays 0.
REQ-033 raw_in high for cycles 10-12, then low -> clean_out, rise_out and evt_out stay 0 throughout.
REQ-034 raw_in bounces 1,0,1,0 then holds 1 from cycle 20 -> exactly one rise_out, in cycle 26.
REQ-035 With edge_sel_in=10: press then release, each held 10 cycles -> evt_out pulses once, on the fall only; repeated with 00 -> no evt_out; with 11 -> two pulses.
REQ-036 rst_in pulsed for one cycle while PEND_HI with counter=2 -> all outputs 0 the next cycle, no rise_out; raw_in still high -> rise_out exactly 6 cycles after reset release.
REQ-037 With DEBOUNCE_CYCLES=1 in a separate build, a raw_in step -> clean_out follows after 3 cycles with one pulse, and a 1-cycle raw glitch still produces rise then fall.

Source files
------------

// File: rtl/evt_pkg.sv
// Shared types for the event debouncer: FSM state encoding and edge-select codes.
package evt_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } state_t;

    localparam logic [1:0] EDGE_NONE = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk_in domain.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic d_in,
    output logic q_out
);

    logic [STAGES-1:0] sync_p0;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[STAGES-2:0], d_in};
        end
    end

    assign q_out = sync_p0[STAGES-1];

endmodule

// File: rtl/evt_debounce.sv
// Debounces a bouncy asynchronous input and emits one-cycle pulses on accepted level changes.
module evt_debounce
    import evt_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       raw_in,
    input  logic [1:0] edge_sel_in,
    output logic       clean_out,
    output logic       rise_out,
    output logic       fall_out,
    output logic       evt_out
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // A pending change is accepted on the sample that brings the run to DEBOUNCE_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d_in   (raw_in),
        .q_out  (sync)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= STABLE_LO;
            cnt       <= '0;
            clean_out <= 1'b0;
            rise_out  <= 1'b0;
            fall_out  <= 1'b0;
        end else begin
            rise_out <= 1'b0;
            fall_out <= 1'b0;
            case (state)
                STABLE_LO: begin
                    if (sync) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state     <= STABLE_HI;
                            cnt       <= '0;
                            clean_out <= 1'b1;
                            rise_out  <= 1'b1;
                        end else begin
                            state <= PEND_HI;
                            cnt   <= CNT_ONE;
                        end
                    end
                end
                PEND_HI: begin
                    if (!sync) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= STABLE_HI;
                        cnt       <= '0;
                        clean_out <= 1'b1;
                        rise_out  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!sync) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state     <= STABLE_LO;
                            cnt       <= '0;
                            clean_out <= 1'b0;
                            fall_out  <= 1'b1;
                        end else begin
                            state <= PEND_LO;
                            cnt   <= CNT_ONE;
                        end
                    end
                end
                PEND_LO: begin
                    if (sync) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= STABLE_LO;
                        cnt       <= '0;
                        clean_out <= 1'b0;
                        fall_out  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= STABLE_LO;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Selection is combinational so edge_sel_in changes apply in the same cycle.
    assign evt_out = (rise_out & edge_sel_in[0]) | (fall_out & edge_sel_in[1]);

endmodule

// File: tb/tb_evt_debounce.sv
// Checks evt_debounce (DEBOUNCE_CYCLES=4 and =1 builds) against a run-length reference model.
module tb_evt_debounce;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       raw_in;
    logic [1:0] edge_sel_in;

    logic clean4, rise4, fall4, evt4;
    logic clean1, rise1, fall1, evt1;

    int errors = 0;
    int checks = 0;

    // Reference model: sync samples delayed through a queue, plus run length of differing samples.
    localparam int SYNC = 2;
    int  dcyc [2] = '{4, 1};
    bit  hist [$];
    bit  mclean [2];
    bit  mrise  [2];
    bit  mfall  [2];
    int  mrun   [2];
    int  n_rise [2];
    int  n_fall [2];
    int  n_evt  [2];

    always #5 clk_in = ~clk_in;

    evt_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut4 (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .raw_in      (raw_in),
        .edge_sel_in (edge_sel_in),
        .clean_out   (clean4),
        .rise_out    (rise4),
        .fall_out    (fall4),
        .evt_out     (evt4)
    );

    evt_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) dut1 (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .raw_in      (raw_in),
        .edge_sel_in (edge_sel_in),
        .clean_out   (clean1),
        .rise_out    (rise1),
        .fall_out    (fall1),
        .evt_out     (evt1)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit raw);
        bit seen;
        if (rst) begin
            hist.delete();
            for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
            for (int d = 0; d < 2; d++) begin
                mclean[d] = 0; mrise[d] = 0; mfall[d] = 0; mrun[d] = 0;
            end
        end else begin
            seen = hist.pop_front();
            hist.push_back(raw);
            for (int d = 0; d < 2; d++) begin
                mrise[d] = 0;
                mfall[d] = 0;
                if (seen != mclean[d]) begin
                    mrun[d]++;
                    if (mrun[d] == dcyc[d]) begin
                        mclean[d] = seen;
                        mrise[d]  = seen;
                        mfall[d]  = !seen;
                        mrun[d]   = 0;
                    end
                end else begin
                    mrun[d] = 0;
                end
            end
        end
    endtask

    // One clock: model follows the edge, DUT outputs are compared 1 ns later.
    task automatic tick();
        bit r, s;
        r = rst_in;
        s = raw_in;
        @(posedge clk_in);
        model_edge(r, s);
        #1;
        chk("clean4", clean4, mclean[0]);
        chk("rise4",  rise4,  mrise[0]);
        chk("fall4",  fall4,  mfall[0]);
        chk("evt4",   evt4,   (mrise[0] & edge_sel_in[0]) | (mfall[0] & edge_sel_in[1]));
        chk("clean1", clean1, mclean[1]);
        chk("rise1",  rise1,  mrise[1]);
        chk("fall1",  fall1,  mfall[1]);
        chk("evt1",   evt1,   (mrise[1] & edge_sel_in[0]) | (mfall[1] & edge_sel_in[1]));
        n_rise[0] += int'(rise4); n_fall[0] += int'(fall4); n_evt[0] += int'(evt4);
        n_rise[1] += int'(rise1); n_fall[1] += int'(fall1); n_evt[1] += int'(evt1);
    endtask

    task automatic clr_counts();
        for (int d = 0; d < 2; d++) begin
            n_rise[d] = 0; n_fall[d] = 0; n_evt[d] = 0;
        end
    endtask

    task automatic chk_cnt(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int hold;
        rst_in = 1'b1;
        raw_in = 1'b0;
        edge_sel_in = 2'b11;
        for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
        tick();
        tick();
        chk("reset_clean4", clean4, 1'b0);
        chk("reset_rise1",  rise1,  1'b0);
        rst_in = 1'b0;
        idle(5);

        // Clean press: D=4 build accepts on the 6th edge, D=1 build on the 3rd.
        clr_counts();
        raw_in = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("lat_clean4", clean4, i >= 6);
            chk("lat_rise4",  rise4,  i == 6);
            chk("lat_clean1", clean1, i >= 3);
            chk("lat_rise1",  rise1,  i == 3);
        end
        chk_cnt("press_fall4", n_fall[0], 0);
        raw_in = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("lat_fall4", fall4, i == 6);
            chk("lat_fall1", fall1, i == 3);
        end

        // Short 3-cycle pulse is rejected by the D=4 build.
        clr_counts();
        raw_in = 1'b1;
        idle(3);
        raw_in = 1'b0;
        idle(12);
        chk_cnt("short_rise4", n_rise[0], 0);
        chk_cnt("short_evt4",  n_evt[0], 0);
        chk_cnt("short_rise1", n_rise[1], 1);

        // Bounce 1,0,1,0 then hold high: one rise only.
        clr_counts();
        raw_in = 1'b1; tick();
        raw_in = 1'b0; tick();
        raw_in = 1'b1; tick();
        raw_in = 1'b0; tick();
        raw_in = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("bounce_rise4", rise4, i == 6);
        end
        chk_cnt("bounce_nrise4", n_rise[0], 1);
        raw_in = 1'b0;
        idle(10);

        // Edge selection: fall only, none, both.
        for (int k = 0; k < 3; k++) begin
            edge_sel_in = (k == 0) ? 2'b10 : (k == 1) ? 2'b00 : 2'b11;
            clr_counts();
            raw_in = 1'b1; idle(10);
            raw_in = 1'b0; idle(10);
            chk_cnt("sel_evt4", n_evt[0], (k == 0) ? 1 : (k == 1) ? 0 : 2);
            chk_cnt("sel_evt1", n_evt[1], (k == 0) ? 1 : (k == 1) ? 0 : 2);
        end

        // 1-cycle glitch on the D=1 build: rise then fall.
        clr_counts();
        raw_in = 1'b1; tick();
        raw_in = 1'b0; idle(8);
        chk_cnt("glitch_rise1", n_rise[1], 1);
        chk_cnt("glitch_fall1", n_fall[1], 1);
        chk_cnt("glitch_rise4", n_rise[0], 0);

        // Reset while pending with count 2 discards the change; held input re-debounces.
        raw_in = 1'b1;
        idle(4);
        rst_in = 1'b1;
        tick();
        chk("rst_clean4", clean4, 1'b0);
        chk("rst_rise4",  rise4,  1'b0);
        chk("rst_fall4",  fall4,  1'b0);
        rst_in = 1'b0;
        clr_counts();
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("rel_rise4", rise4, i == 6);
        end
        chk_cnt("rel_nrise4", n_rise[0], 1);
        raw_in = 1'b0;
        idle(10);

        // Randomized traffic with sporadic resets and edge-select changes.
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                raw_in = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 8);
            end
            hold--;
            if ($urandom_range(0, 15) == 0) edge_sel_in = 2'($urandom_range(0, 3));
            rst_in = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst_in = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
